// File: rtl/dataplane_pkg.sv
// Shared dataplane definitions: packer FSM states and width helpers
// that derive lane and counter widths from a word width in bits.
package dataplane_pkg;

  localparam int DEFAULT_DATA_WIDTH = 64;
  localparam int BYTES              = DEFAULT_DATA_WIDTH / 8;
  localparam int IDX_W              = $clog2(BYTES + 1);

  typedef enum logic [0:0] {
    FILL = 1'b0,
    HOLD = 1'b1
  } packerState_t;

  // Number of byte lanes in a word of the given width.
  function automatic int bytesOf(input int dataWidth);
    return dataWidth / 8;
  endfunction

  // Width needed to count 0..bytes valid bytes in a word.
  function automatic int idxWidthOf(input int dataWidth);
    return $clog2(dataWidth / 8 + 1);
  endfunction

  // Width of the lane pointer; never narrower than one bit.
  function automatic int cntWidthOf(input int dataWidth);
    return (dataWidth / 8 > 1) ? $clog2(dataWidth / 8) : 1;
  endfunction

endpackage

// File: rtl/byte_packer.sv
// Byte packer: collects an AXI-Stream byte stream into little-endian
// words (first byte in lane 0). A completed word moves into a single
// output register. If that register is still occupied, the accumulator
// freezes in HOLD and ingress stalls until the parser frees the slot.
module byte_packer
  import dataplane_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  localparam int LANES     = bytesOf(DATA_WIDTH),
  localparam int IDX_BITS  = idxWidthOf(DATA_WIDTH),
  localparam int CNT_BITS  = cntWidthOf(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [7:0]            s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  output logic [DATA_WIDTH-1:0] data_buffer,
  output logic [IDX_BITS-1:0]   idx,
  output logic                  last_flag,
  output logic                  word_valid,
  input  logic                  parser_ready,
  output logic [15:0]           frame_count
);

  packerState_t          r_state;
  packerState_t          w_nextState;

  logic [DATA_WIDTH-1:0] r_acc;
  logic [CNT_BITS-1:0]   r_cnt;
  logic                  r_accLast;

  logic [DATA_WIDTH-1:0] r_dataBuffer;
  logic [IDX_BITS-1:0]   r_idx;
  logic                  r_lastFlag;
  logic                  r_wordValid;
  logic [15:0]           r_frameCount;

  logic [DATA_WIDTH-1:0] w_accMerged;
  logic [IDX_BITS-1:0]   w_wordIdx;
  logic                  w_accept;
  logic                  w_complete;
  logic                  w_slotFree;
  logic                  w_transfer;
  logic                  w_loadFromIn;
  logic                  w_loadFromAcc;

  assign w_accept   = s_axis_tvalid && s_axis_tready;
  assign w_complete = w_accept && ((r_cnt == CNT_BITS'(LANES - 1)) || s_axis_tlast);
  assign w_slotFree = !r_wordValid || parser_ready;
  assign w_transfer = r_wordValid && parser_ready;
  assign w_wordIdx  = IDX_BITS'(r_cnt) + IDX_BITS'(1);

  // Accumulator contents with the incoming byte dropped into lane cnt.
  always_comb begin
    w_accMerged = r_acc;
    for (int k = 0; k < LANES; k++) begin
      if (r_cnt == CNT_BITS'(k)) begin
        w_accMerged[8*k +: 8] = s_axis_tdata;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= FILL;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next state: park in HOLD when a word completes into an occupied slot.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      FILL:    if (w_complete && !w_slotFree) w_nextState = HOLD;
      HOLD:    if (w_slotFree)                w_nextState = FILL;
      default: w_nextState = FILL;
    endcase
  end

  // FSM outputs: ingress ready and which source loads the output register.
  always_comb begin
    s_axis_tready = rst_n && (r_state == FILL);
    w_loadFromIn  = (r_state == FILL) && w_complete && w_slotFree;
    w_loadFromAcc = (r_state == HOLD) && w_slotFree;
  end

  // Accumulator: gather bytes, freeze while held, clear once handed off.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_acc     <= '0;
      r_cnt     <= '0;
      r_accLast <= 1'b0;
    end else if (w_loadFromIn || w_loadFromAcc) begin
      r_acc     <= '0;
      r_cnt     <= '0;
      r_accLast <= 1'b0;
    end else if (w_accept) begin
      r_acc     <= w_accMerged;
      r_accLast <= s_axis_tlast;
      if (!w_complete) begin
        r_cnt <= r_cnt + CNT_BITS'(1);
      end
    end
  end

  // Output register: a load wins over a transfer so words go out back to back.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_dataBuffer <= '0;
      r_idx        <= '0;
      r_lastFlag   <= 1'b0;
      r_wordValid  <= 1'b0;
    end else if (w_loadFromIn) begin
      r_dataBuffer <= w_accMerged;
      r_idx        <= w_wordIdx;
      r_lastFlag   <= s_axis_tlast;
      r_wordValid  <= 1'b1;
    end else if (w_loadFromAcc) begin
      r_dataBuffer <= r_acc;
      r_idx        <= w_wordIdx;
      r_lastFlag   <= r_accLast;
      r_wordValid  <= 1'b1;
    end else if (w_transfer) begin
      r_dataBuffer <= '0;
      r_idx        <= '0;
      r_lastFlag   <= 1'b0;
      r_wordValid  <= 1'b0;
    end
  end

  // Count frames as their final word leaves toward the parser.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_frameCount <= '0;
    end else if (w_transfer && r_lastFlag) begin
      r_frameCount <= r_frameCount + 16'd1;
    end
  end

  assign data_buffer = r_dataBuffer;
  assign idx         = r_idx;
  assign last_flag   = r_lastFlag;
  assign word_valid  = r_wordValid;
  assign frame_count = r_frameCount;

endmodule

// File: tb/tb_byte_packer.sv
// Directed testbench for byte_packer with the default 64-bit word.
module tb_byte_packer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  s_axis_tdata;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic        s_axis_tlast;
  logic [63:0] data_buffer;
  logic [3:0]  idx;
  logic        last_flag;
  logic        word_valid;
  logic        parser_ready;
  logic [15:0] frame_count;

  int checks   = 0;
  int failures = 0;
  int stalls   = 0;

  bit          collectOn = 1'b1;
  logic [63:0] qData[$];
  logic [3:0]  qIdx[$];
  logic        qLast[$];

  byte_packer #(.DATA_WIDTH(64)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tlast  (s_axis_tlast),
    .data_buffer   (data_buffer),
    .idx           (idx),
    .last_flag     (last_flag),
    .word_valid    (word_valid),
    .parser_ready  (parser_ready),
    .frame_count   (frame_count)
  );

  always #5 clk = ~clk;

  // Record every word handed to the parser, sampled mid-cycle.
  always @(negedge clk) begin
    if (collectOn && word_valid === 1'b1 && parser_ready === 1'b1) begin
      qData.push_back(data_buffer);
      qIdx.push_back(idx);
      qLast.push_back(last_flag);
    end
  end

  task automatic clearQueue();
    qData.delete();
    qIdx.delete();
    qLast.delete();
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Offer one byte and hold it until accepted (bounded).
  task automatic sendByte(input logic [7:0] d, input logic l);
    int   guard;
    logic acc;
    guard = 0;
    acc = 1'b0;
    s_axis_tdata  = d;
    s_axis_tlast  = l;
    s_axis_tvalid = 1'b1;
    while (!acc && guard < 200) begin
      @(negedge clk);
      acc = (s_axis_tready === 1'b1);
      @(posedge clk);
      #1;
      guard++;
    end
    if (guard > 1) stalls++;
    checks++;
    if (!acc) begin
      failures++;
      $display("[TB] FAIL byte_accept_timeout data=%02h got no acceptance expected acceptance", d);
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast = 1'b0;
    s_axis_tdata = 8'h00;
    parser_ready = 1'b0;
    waitCycles(3);
    @(negedge clk);
    checks++; if (s_axis_tready !== 1'b0) begin failures++; $display("[TB] FAIL reset_tready got=%b exp=0", s_axis_tready); end
    checks++; if (word_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_word_valid got=%b exp=0", word_valid); end
    checks++; if (idx !== 4'd0) begin failures++; $display("[TB] FAIL reset_idx got=%0d exp=0", idx); end
    checks++; if (last_flag !== 1'b0) begin failures++; $display("[TB] FAIL reset_last got=%b exp=0", last_flag); end
    checks++; if (data_buffer !== 64'h0) begin failures++; $display("[TB] FAIL reset_data got=%h exp=0", data_buffer); end
    checks++; if (frame_count !== 16'h0) begin failures++; $display("[TB] FAIL reset_frame_count got=%h exp=0", frame_count); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (s_axis_tready !== 1'b1) begin failures++; $display("[TB] FAIL release_tready got=%b exp=1", s_axis_tready); end
    @(posedge clk); #1;
  endtask

  task automatic test_ten_bytes();
    clearQueue();
    parser_ready = 1'b1;
    for (int i = 1; i <= 10; i++) sendByte(8'(i), (i == 10));
    waitCycles(3);
    checks++; if (qData.size() != 2) begin failures++; $display("[TB] FAIL ten_word_count got=%0d exp=2", qData.size()); end
    if (qData.size() == 2) begin
      checks++; if (qData[0] !== 64'h0807060504030201) begin failures++; $display("[TB] FAIL ten_w0_data got=%h exp=0807060504030201", qData[0]); end
      checks++; if (qIdx[0] !== 4'd8 || qLast[0] !== 1'b0) begin failures++; $display("[TB] FAIL ten_w0_meta got idx=%0d last=%b exp idx=8 last=0", qIdx[0], qLast[0]); end
      checks++; if (qData[1] !== 64'h0000000000000A09) begin failures++; $display("[TB] FAIL ten_w1_data got=%h exp=0000000000000a09", qData[1]); end
      checks++; if (qIdx[1] !== 4'd2 || qLast[1] !== 1'b1) begin failures++; $display("[TB] FAIL ten_w1_meta got idx=%0d last=%b exp idx=2 last=1", qIdx[1], qLast[1]); end
    end
    checks++; if (frame_count !== 16'd1) begin failures++; $display("[TB] FAIL ten_frame_count got=%0d exp=1", frame_count); end
    checks++; if (word_valid !== 1'b0 || idx !== 4'd0 || last_flag !== 1'b0) begin failures++; $display("[TB] FAIL ten_idle got valid=%b idx=%0d last=%b exp 0/0/0", word_valid, idx, last_flag); end
  endtask

  task automatic test_single_byte();
    parser_ready = 1'b1;
    checks++; if (word_valid !== 1'b0) begin failures++; $display("[TB] FAIL single_pre_valid got=%b exp=0", word_valid); end
    sendByte(8'hAB, 1'b1);
    checks++; if (word_valid !== 1'b1) begin failures++; $display("[TB] FAIL single_valid got=%b exp=1", word_valid); end
    checks++; if (data_buffer !== 64'h00000000000000AB) begin failures++; $display("[TB] FAIL single_data got=%h exp=00000000000000ab", data_buffer); end
    checks++; if (idx !== 4'd1 || last_flag !== 1'b1) begin failures++; $display("[TB] FAIL single_meta got idx=%0d last=%b exp idx=1 last=1", idx, last_flag); end
    waitCycles(2);
    checks++; if (frame_count !== 16'd2) begin failures++; $display("[TB] FAIL single_frame_count got=%0d exp=2", frame_count); end
  endtask

  task automatic test_hold();
    clearQueue();
    parser_ready = 1'b0;
    for (int i = 0; i < 16; i++) sendByte(8'(8'h10 + i), (i == 15));
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++;
      if (s_axis_tready !== 1'b0 || word_valid !== 1'b1 || data_buffer !== 64'h1716151413121110 || idx !== 4'd8 || last_flag !== 1'b0) begin
        failures++;
        $display("[TB] FAIL hold_stable cyc=%0d got rdy=%b v=%b d=%h idx=%0d last=%b exp rdy=0 v=1 d=1716151413121110 idx=8 last=0", c, s_axis_tready, word_valid, data_buffer, idx, last_flag);
      end
    end
    @(posedge clk); #1;
    parser_ready = 1'b1;
    waitCycles(1);
    @(negedge clk);
    checks++; if (s_axis_tready !== 1'b1) begin failures++; $display("[TB] FAIL hold_release_tready got=%b exp=1", s_axis_tready); end
    waitCycles(3);
    checks++; if (qData.size() != 2) begin failures++; $display("[TB] FAIL hold_word_count got=%0d exp=2", qData.size()); end
    if (qData.size() == 2) begin
      checks++; if (qData[0] !== 64'h1716151413121110 || qIdx[0] !== 4'd8 || qLast[0] !== 1'b0) begin failures++; $display("[TB] FAIL hold_w0 got d=%h idx=%0d last=%b exp d=1716151413121110 idx=8 last=0", qData[0], qIdx[0], qLast[0]); end
      checks++; if (qData[1] !== 64'h1F1E1D1C1B1A1918 || qIdx[1] !== 4'd8 || qLast[1] !== 1'b1) begin failures++; $display("[TB] FAIL hold_w1 got d=%h idx=%0d last=%b exp d=1f1e1d1c1b1a1918 idx=8 last=1", qData[1], qIdx[1], qLast[1]); end
    end
    checks++; if (frame_count !== 16'd3) begin failures++; $display("[TB] FAIL hold_frame_count got=%0d exp=3", frame_count); end
  endtask

  task automatic test_back_to_back();
    logic [63:0] exp;
    clearQueue();
    parser_ready = 1'b1;
    stalls = 0;
    for (int i = 0; i < 64; i++) sendByte(8'(i), (i == 63));
    waitCycles(3);
    checks++; if (stalls != 0) begin failures++; $display("[TB] FAIL b2b_stalls got=%0d exp=0", stalls); end
    checks++; if (qData.size() != 8) begin failures++; $display("[TB] FAIL b2b_word_count got=%0d exp=8", qData.size()); end
    if (qData.size() == 8) begin
      for (int w = 0; w < 8; w++) begin
        for (int k = 0; k < 8; k++) exp[8*k +: 8] = 8'(8*w + k);
        checks++;
        if (qData[w] !== exp || qIdx[w] !== 4'd8 || qLast[w] !== (w == 7)) begin
          failures++;
          $display("[TB] FAIL b2b_word%0d got d=%h idx=%0d last=%b exp d=%h idx=8 last=%b", w, qData[w], qIdx[w], qLast[w], exp, (w == 7));
        end
      end
    end
    checks++; if (frame_count !== 16'd4) begin failures++; $display("[TB] FAIL b2b_frame_count got=%0d exp=4", frame_count); end
  endtask

  task automatic test_mid_reset();
    clearQueue();
    parser_ready = 1'b1;
    for (int i = 0; i < 3; i++) sendByte(8'(8'hC0 + i), 1'b0);
    rst_n = 1'b0;
    waitCycles(1);
    rst_n = 1'b1;
    waitCycles(2);
    checks++; if (qData.size() != 0) begin failures++; $display("[TB] FAIL midrst_no_word got=%0d exp=0", qData.size()); end
    checks++; if (word_valid !== 1'b0 || data_buffer !== 64'h0 || idx !== 4'd0 || last_flag !== 1'b0 || frame_count !== 16'd0) begin
      failures++;
      $display("[TB] FAIL midrst_outputs got v=%b d=%h idx=%0d last=%b fc=%0d exp all 0", word_valid, data_buffer, idx, last_flag, frame_count);
    end
    for (int i = 0; i < 8; i++) sendByte(8'(8'hD0 + i), (i == 7));
    waitCycles(3);
    checks++; if (qData.size() != 1) begin failures++; $display("[TB] FAIL midrst_word_count got=%0d exp=1", qData.size()); end
    if (qData.size() == 1) begin
      checks++; if (qData[0] !== 64'hD7D6D5D4D3D2D1D0 || qIdx[0] !== 4'd8 || qLast[0] !== 1'b1) begin failures++; $display("[TB] FAIL midrst_word got d=%h idx=%0d last=%b exp d=d7d6d5d4d3d2d1d0 idx=8 last=1", qData[0], qIdx[0], qLast[0]); end
    end
  endtask

  task automatic test_frame_wrap();
    collectOn = 1'b0;
    rst_n = 1'b0;
    waitCycles(1);
    rst_n = 1'b1;
    waitCycles(1);
    parser_ready = 1'b1;
    s_axis_tdata = 8'h5A;
    s_axis_tlast = 1'b1;
    s_axis_tvalid = 1'b1;
    repeat (65535) @(posedge clk);
    #1;
    s_axis_tvalid = 1'b0;
    s_axis_tlast = 1'b0;
    waitCycles(2);
    checks++; if (frame_count !== 16'hFFFF) begin failures++; $display("[TB] FAIL wrap_preload got=%h exp=ffff", frame_count); end
    sendByte(8'h77, 1'b1);
    waitCycles(2);
    checks++; if (frame_count !== 16'h0000) begin failures++; $display("[TB] FAIL wrap_rollover got=%h exp=0000", frame_count); end
    collectOn = 1'b1;
  endtask

  // Run each scenario in order, then report.
  initial begin
    test_reset();
    test_ten_bytes();
    test_single_byte();
    test_hold();
    test_back_to_back();
    test_mid_reset();
    test_frame_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/byte_packer.md
BYTE_PACKER -- requirements
Module: byte_packer

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 64, giving the output word width in bits; it SHALL be a multiple of 8, with BYTES = DATA_WIDTH/8.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all logic is clocked on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-004 The block SHALL have port s_axis_tdata, input, 8 bits: ingress byte.
REQ-005 The block SHALL have port s_axis_tvalid, input, 1 bit: ingress byte valid.
REQ-006 The block SHALL have port s_axis_tready, output, 1 bit: ingress byte accepted when tvalid and tready are both high.
REQ-007 The block SHALL have port s_axis_tlast, input, 1 bit: the current byte is the final byte of the frame.
REQ-008 The block SHALL have port data_buffer, output, DATA_WIDTH bits: packed word sent to the parser.
REQ-009 The block SHALL have port idx, output, $clog2(BYTES+1) bits: count of valid bytes in data_buffer.
REQ-010 The block SHALL have port last_flag, output, 1 bit: the word holds the final byte of a frame.
REQ-011 The block SHALL have port word_valid, output, 1 bit: data_buffer, idx and last_flag are valid.
REQ-012 The block SHALL have port parser_ready, input, 1 bit: the parser accepts the word.
REQ-013 The block SHALL have port frame_count, output, 16 bits: number of frames completed on the output side.

Function
REQ-014 Byte k of a word (k = 0..BYTES-1) SHALL occupy data_buffer[8k+7:8k]; the first received byte SHALL go to lane 0.
REQ-015 Unfilled lanes of a short word SHALL be zero.
REQ-016 The block SHALL contain an accumulator with byte counter cnt (0..BYTES-1), an output register, and a two-state FSM with states FILL and HOLD.
REQ-017 In FILL, s_axis_tready SHALL be 1; each accepted byte SHALL be written to lane cnt, and cnt SHALL increment.
REQ-018 A word SHALL complete on an accepted byte when cnt == BYTES-1 or s_axis_tlast = 1.
REQ-019 The output slot SHALL be free in a cycle when word_valid = 0 or parser_ready = 1.
REQ-020 On completion with the slot free, the completed word SHALL load the output register on that edge and cnt SHALL clear to 0.
- word_valid SHALL assert on the next cycle (1-cycle latency).
- idx SHALL equal the byte count of the word (1..BYTES).
- last_flag SHALL equal the tlast of the completing byte.
- The FSM SHALL stay in FILL.
REQ-021 On completion with the slot not free, the FSM SHALL enter HOLD with the accumulator frozen; s_axis_tready SHALL be 0 while in HOLD.
REQ-022 In HOLD, when the slot becomes free, the accumulator SHALL load the output register, cnt SHALL clear, and the FSM SHALL return to FILL; s_axis_tready SHALL be 1 from the following cycle.
REQ-023 A word SHALL transfer to the parser when word_valid = 1 and parser_ready = 1 in the same cycle.
- After a transfer, word_valid SHALL drop unless a new word loads on the same edge.
- A transfer and a load on the same edge SHALL give back-to-back words with no bubble.
REQ-024 While word_valid = 1 and parser_ready = 0, data_buffer, idx and last_flag SHALL hold stable.
REQ-025 When word_valid = 0, idx SHALL be 0 and last_flag SHALL be 0.
REQ-026 frame_count SHALL increment by 1 on each transfer with last_flag = 1, and SHALL wrap from 0xFFFF to 0x0000.
REQ-027 A 1-byte frame (tlast on the first byte) SHALL produce one word with idx = 1 and last_flag = 1.
REQ-028 A frame whose length is an exact multiple of BYTES SHALL end with a full word (idx = BYTES, last_flag = 1) and no trailing empty word.

Reset
REQ-029 While rst_n = 0 at a clock edge, the block SHALL set:
- FSM to FILL, cnt to 0, accumulator to 0;
- word_valid, idx, last_flag and data_buffer to 0;
- frame_count to 0.
REQ-030 s_axis_tready SHALL be 0 during reset and 1 on the first cycle after reset release.
REQ-031 A reset in the middle of a frame SHALL discard the partial word and any held or pending word without emitting them.

Structure
REQ-032 BYTES and the idx width SHALL be localparams derived from DATA_WIDTH in the shared dataplane_pkg package; the FSM state typedef SHALL also live there.
REQ-033 The block SHALL be a single module with no sub-module.

Verification
REQ-034 Frame 0x01..0x0A (10 bytes), parser_ready = 1 -> word 0x0807060504030201, idx = 8, last = 0; then 0x0000000000000A09, idx = 2, last = 1; frame_count = 1.
REQ-035 Single byte 0xAB with tlast -> data_buffer = 0x00000000000000AB, idx = 1, last = 1, word_valid one cycle after acceptance.
REQ-036 16-byte frame with parser_ready held 0 -> first word held stable, FSM enters HOLD with tready = 0 after byte 16; raising parser_ready -> both words delivered in order and tready returns to 1.
REQ-037 Continuous tvalid, parser_ready = 1, 64-byte frame -> 8 words on consecutive word boundaries, no stalls, only the final word has last = 1.
REQ-038 rst_n pulsed low after 3 bytes of a frame -> no word emitted, outputs 0; a following 8-byte frame -> exactly one word, idx = 8, last = 1.
REQ-039 frame_count preloaded to 0xFFFF by 65535 one-byte frames; one more frame -> frame_count = 0x0000.
